// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared types and default sizing for the memory stream reader
// Revision: 1.0
// ============================================================================
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_ADDR   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// skid_buf2 : two-entry FIFO; a push into a full buffer succeeds when the
//             head is popped in the same cycle.
// Revision: 1.0
// ============================================================================
module skid_buf2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// mem_stream_reader : reads len words from base_addr (wrapping at MAX_ADDR)
//                     and emits them as a valid/ready stream with last.
// Revision: 1.0
// ============================================================================
module mem_stream_reader
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_ADDR   = DEF_MAX_ADDR,
    parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDRSIZE-1:0]   base_addr,
    input  logic [ADDRSIZE:0]     len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDRSIZE-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [ADDRSIZE-1:0] c_addr_top = ADDRSIZE'(MAX_ADDR - 1);
    localparam logic [ADDRSIZE:0]   c_rem_one  = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0]   c_rem_zero = '0;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDRSIZE-1:0]   r_addr;
    logic [ADDRSIZE:0]     r_remain;
    logic                  r_done;
    logic                  r_armed;
    logic                  w_rd;
    logic                  w_accept;
    logic                  w_zero_start;
    logic                  w_finish;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [1:0]            w_count;
    logic                  w_has_data;
    logic [DATA_WIDTH:0]   w_head;
    logic [ADDRSIZE-1:0]   w_addr_inc;

    assign w_pop      = !w_empty && out_ready;
    assign w_has_data = (w_count != 2'd0);
    assign w_addr_inc = (r_addr == c_addr_top) ? '0 : r_addr + ADDRSIZE'(1);

    skid_buf2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rd),
        .i_pop   (w_pop),
        .i_din   ({(r_remain == c_rem_one), mem_rd_data}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_rd         = 1'b0;
        w_accept     = 1'b0;
        w_zero_start = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && r_armed) begin
                    if (len != c_rem_zero) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        w_zero_start = 1'b1;
                    end
                end
            end
            ST_READ: begin
                w_rd = !w_full || w_pop;
                if (w_rd && (r_remain == c_rem_one)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last-tagged entry is only ever popped here.
                if (w_pop && w_head[DATA_WIDTH]) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_done   <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_zero_start || w_finish;
            // Suppresses start sampling on the first edge after reset release.
            r_armed <= 1'b1;
            if (w_accept) begin
                r_addr   <= base_addr;
                r_remain <= len;
            end else if (w_rd) begin
                r_addr   <= w_addr_inc;
                r_remain <= r_remain - c_rem_one;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign mem_rd_en   = w_rd;
    assign mem_rd_addr = r_addr;
    assign out_valid   = !w_empty;
    assign out_data    = w_has_data ? w_head[DATA_WIDTH-1:0] : '0;
    assign out_last    = w_has_data && w_head[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`default_nettype none
// ============================================================================
// tb_mem_stream_reader : directed and randomized checks of mem_stream_reader
//                        against a transfer-level reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_stream_reader;

    localparam int DW = 8;
    localparam int MA = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] mem [MA];
    int            passed = 0;
    int            total  = 0;
    int            fails  = 0;

    assign mem_rd_data = mem[mem_rd_addr];

    always #5 clk = ~clk;

    mem_stream_reader #(
        .DATA_WIDTH (DW),
        .MAX_ADDR   (MA),
        .ADDRSIZE   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < MA; i++) mem[i] = DW'(i + 16);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: random.
    task automatic run_xfer(input int b, input int n, input int mode, input bit inject);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] prev_data;
        int  beats = 0;
        int  reads = 0;
        int  occ   = 0;
        int  cyc   = 0;
        bit  fin_prev  = 1'b0;
        bit  stall_prev = 1'b0;
        bit  done_cycle;
        bit  pop;
        bit  exp_rd;
        prev_data = '0;
        for (int k = 0; k < n; k++) exp_q.push_back(mem[(b + k) % MA]);
        @(negedge clk);
        start = 1'b1; base_addr = AW'(b); len = (AW+1)'(n); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 200) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && cyc == 2) begin
                start = 1'b1; base_addr = AW'(b ^ 5); len = (AW+1)'(9);
            end
            if (inject && cyc == 3) start = 1'b0;
            #1;
            done_cycle = fin_prev;
            chk("busy", busy, (beats < n));
            chk("done", done, done_cycle);
            chk("out_valid", out_valid, (occ > 0));
            pop    = (occ > 0) && out_ready;
            exp_rd = (reads < n) && (occ < 2 || pop);
            chk("mem_rd_en", mem_rd_en, exp_rd);
            if (mem_rd_en) begin
                chk("rd_addr", mem_rd_addr, (b + reads) % MA);
            end
            if (occ > 0) begin
                if (stall_prev) chk("stall_data", out_data, prev_data);
                if (out_ready && beats < n) begin
                    chk("out_data", out_data, exp_q[beats]);
                    chk("out_last", out_last, (beats == n - 1));
                    beats++;
                end
            end
            stall_prev = (occ > 0) && !out_ready;
            prev_data  = out_data;
            fin_prev   = pop && (beats == n);
            occ        = occ + (exp_rd ? 1 : 0) - (pop ? 1 : 0);
            if (exp_rd) reads++;
            @(negedge clk);
            cyc++;
            if (done_cycle) break;
        end
        out_ready = 1'b0;
        #1;
        chk("xfer_complete", beats, n);
        chk("done_single", done, 1'b0);
        chk("idle_after", busy, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_done"},  done, 1'b0);
        chk({tag, "_rd_en"}, mem_rd_en, 1'b0);
        chk({tag, "_addr"},  mem_rd_addr, 0);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_last"},  out_last, 1'b0);
        chk({tag, "_data"},  out_data, 0);
    endtask

    initial begin
        int hs;
        fill_ramp();
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(3, 4, 0, 1'b0);
        run_xfer(14, 4, 0, 1'b0);
        run_xfer(2, 5, 1, 1'b0);

        // Zero-length start: done next cycle, no reads, never busy.
        @(negedge clk);
        start = 1'b1; base_addr = AW'(7); len = '0;
        #1;
        chk("len0_rd_en_start", mem_rd_en, 1'b0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b0);
        chk("len0_rd_en", mem_rd_en, 1'b0);
        @(negedge clk);
        #1;
        chk("len0_done_clr", done, 1'b0);
        chk("len0_busy2", busy, 1'b0);

        run_xfer(6, 6, 0, 1'b1);
        run_xfer(0, 16, 2, 1'b0);

        for (int i = 0; i < MA; i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 6; t++) begin
            run_xfer(int'($urandom_range(0, MA - 1)), int'($urandom_range(1, MA)), 2, 1'b0);
        end

        // Reset in the middle of a 6-beat transfer after 2 beats.
        fill_ramp();
        @(negedge clk);
        start = 1'b1; base_addr = '0; len = (AW+1)'(6); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            #1;
            if (out_valid && out_ready) hs++;
            @(negedge clk);
        end
        chk("mid_hs_count", hs, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        #1;
        chk("mid_reset_done_hold", done, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("post_reset_done", done, 1'b0);
            chk("post_reset_valid", out_valid, 1'b0);
        end
        run_xfer(3, 4, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, 8, width of one memory word and of the output stream data.
REQ-002 Parameter MAX_ADDR, 16, number of words in the memory being read; addresses run 0..MAX_ADDR-1.
REQ-003 Parameter ADDRSIZE, $clog2(MAX_ADDR), memory address width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  begin a transfer; sampled only in IDLE.
REQ-007 base_addr  input  ADDRSIZE  first word address; sampled with start.
REQ-008 len  input  ADDRSIZE+1  word count, 0..MAX_ADDR; sampled with start.
REQ-009 busy  output  1  high while a transfer is in progress.
REQ-010 done  output  1  one-cycle pulse at transfer end.
REQ-011 mem_rd_en  output  1  memory read strobe.
REQ-012 mem_rd_addr  output  ADDRSIZE  memory read address.
REQ-013 mem_rd_data  input  DATA_WIDTH  memory read data, combinationally valid in the same cycle as mem_rd_en.
REQ-014 out_valid / out_ready  output / input  1 each  stream handshake; a beat transfers when both are high at a rising edge.
REQ-015 out_data  output  DATA_WIDTH  stream data.
REQ-016 out_last  output  1  high with the final beat of a transfer.

Function
REQ-017 FSM states: IDLE, READ, DRAIN. busy is high in READ and DRAIN and low in IDLE.
REQ-018 IDLE to READ: start=1 and len!=0; latch base_addr into the address counter and len into the remaining-issue counter.
REQ-019 IDLE with start=1 and len=0: no reads are issued; done pulses in the next cycle; the state stays IDLE.
REQ-020 A start that arrives while busy is ignored and has no side effects.
REQ-021 Output buffer: 2 entries, FIFO order. out_valid = buffer not empty; out_data and out_last come from the head entry.
REQ-022 In READ, mem_rd_en=1 when fewer than 2 entries are held, or when 2 are held and the head is popped in the same cycle. The word is written into the buffer at that edge.
REQ-023 mem_rd_en is low in IDLE and DRAIN; mem_rd_addr holds the current address counter.
REQ-024 Each read increments the address counter modulo MAX_ADDR: MAX_ADDR-1 wraps to 0. For MAX_ADDR that is not a power of 2, wrap is explicit.
REQ-025 The entry written by the final read (remaining count 1) carries last=1.
REQ-026 READ to DRAIN on the final read. DRAIN to IDLE on the handshake of the last beat. done pulses in the cycle after that handshake, when busy is already low.
REQ-027 Latency: start in cycle N gives the first mem_rd_en in cycle N+1 and the first out_valid in cycle N+2. With out_ready held high, throughput is 1 beat per cycle.
REQ-028 out_valid, once asserted, stays high with out_data stable until the beat is accepted.
REQ-029 The read counter never issues more than len reads; exactly len beats are emitted per transfer.

Reset
REQ-030 rst_n low asynchronously forces IDLE, clears the buffer and the counters, and drives busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_last=0, out_data=0.
REQ-031 Reset during a transfer aborts it with no done pulse. Buffered beats are discarded.
REQ-032 Release of rst_n takes effect at the next rising clk edge; start is not sampled in the cycle rst_n rises.

Structure
REQ-033 A shared package mem_pkg holds the FSM state enum (IDLE, READ, DRAIN) and the default DATA_WIDTH/MAX_ADDR constants, and is shared with mem_mod users.
REQ-034 The 2-entry buffer is one sub-module, skid_buf2, parameterised on width DATA_WIDTH+1 to carry data plus last, with push, pop, full, empty and count ports.

Verification
REQ-035 Memory preloaded with mem[i]=i+0x10, base=3, len=4, out_ready=1 -> beats 0x13, 0x14, 0x15, 0x16 on consecutive cycles; out_last on 0x16; done pulses exactly once; busy is low in the done cycle.
REQ-036 base=14, len=4, MAX_ADDR=16 -> reads at addresses 14, 15, 0, 1; beats 0x1E, 0x1F, 0x10, 0x11.
REQ-037 len=5 with out_ready toggling 1,0,0,1,... -> no more than 2 beats buffered; no mem_rd_en while the buffer is full without a pop; data stable while stalled; 5 beats in order.
REQ-038 start with len=0 -> mem_rd_en never asserted; done pulses one cycle after start; busy stays 0.
REQ-039 start during busy with different base/len -> ignored; the original transfer completes unchanged.
REQ-040 rst_n driven low mid-transfer after 2 of 6 beats -> all outputs go to their reset values immediately; no done pulse; a new transfer after release behaves per REQ-035.
